// File: rtl/gd_sequencer.sv
// Gradient-descent sequencer: walks weights then biases, feeds the GD unit
// and writes updated parameters back on a fixed 3-cycle pipeline.
module gd_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] lr_in,
  input  logic [7:0]  num_weights_in,
  input  logic [3:0]  num_biases_in,
  input  logic [3:0]  batch_in,
  output logic        param_rd_en,
  output logic [9:0]  param_rd_addr,
  input  logic [15:0] param_rd_data,
  output logic        grad_rd_en,
  output logic [9:0]  grad_rd_addr,
  input  logic [15:0] grad_rd_data,
  output logic [15:0] gd_lr_out,
  output logic [15:0] gd_value_old_out,
  output logic [15:0] gd_grad_out,
  output logic        gd_valid_out,
  output logic        gd_bias_or_weight_out,
  input  logic [15:0] gd_value_updated_in,
  input  logic        gd_done_in,
  output logic        param_wr_en,
  output logic [9:0]  param_wr_addr,
  output logic [15:0] param_wr_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_WEIGHTS, S_BIAS, S_GAP, S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] lr_q, lr_d;
  logic [7:0]  nw_q, nw_d;
  logic [3:0]  nb_q, nb_d;
  logic [3:0]  b_q, b_d;
  logic [7:0]  i_q, i_d;
  logic [3:0]  j_q, j_d;
  logic [3:0]  k_q, k_d;
  logic        done_q, done_d;

  logic        v1_q, bw1_q, wb1_q;
  logic [9:0]  a1_q;
  logic        v2_q, wb2_q;
  logic [9:0]  a2_q;

  logic        iss, iss_bw, iss_wb;
  logic [9:0]  iss_wa;
  logic [9:0]  bias_pa;
  logic [9:0]  bias_ga;

  assign bias_pa = 10'(nw_q) + 10'(j_q);
  assign bias_ga = 10'(nw_q) + 10'(j_q) * 10'(b_q) + 10'(k_q);

  always_comb begin
    state_d       = state_q;
    lr_d          = lr_q;
    nw_d          = nw_q;
    nb_d          = nb_q;
    b_d           = b_q;
    i_d           = i_q;
    j_d           = j_q;
    k_d           = k_q;
    done_d        = 1'b0;
    param_rd_en   = 1'b0;
    param_rd_addr = '0;
    grad_rd_en    = 1'b0;
    grad_rd_addr  = '0;
    iss           = 1'b0;
    iss_bw        = 1'b0;
    iss_wb        = 1'b0;
    iss_wa        = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          lr_d = lr_in;
          nw_d = num_weights_in;
          nb_d = num_biases_in;
          b_d  = (batch_in == 4'd0) ? 4'd1 : batch_in;
          i_d  = '0;
          j_d  = '0;
          k_d  = '0;
          if (num_weights_in != 8'd0)
            state_d = S_WEIGHTS;
          else if (num_biases_in != 4'd0)
            state_d = S_BIAS;
          else
            state_d = S_DRAIN;
        end
      end
      S_WEIGHTS: begin
        param_rd_en   = 1'b1;
        param_rd_addr = {2'b00, i_q};
        grad_rd_en    = 1'b1;
        grad_rd_addr  = {2'b00, i_q};
        iss           = 1'b1;
        iss_bw        = 1'b1;
        iss_wb        = 1'b1;
        iss_wa        = {2'b00, i_q};
        if (i_q == nw_q - 8'd1) begin
          i_d     = '0;
          state_d = (nb_q != 4'd0) ? S_BIAS : S_DRAIN;
        end else begin
          i_d = i_q + 8'd1;
        end
      end
      S_BIAS: begin
        // value_old only matters at k=0; later batches chain in the unit
        param_rd_en   = (k_q == 4'd0);
        param_rd_addr = (k_q == 4'd0) ? bias_pa : 10'd0;
        grad_rd_en    = 1'b1;
        grad_rd_addr  = bias_ga;
        iss           = 1'b1;
        iss_wb        = (k_q == b_q - 4'd1);
        iss_wa        = bias_pa;
        if (k_q == b_q - 4'd1) begin
          k_d     = '0;
          state_d = S_GAP;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      S_GAP: begin
        if (j_q == nb_q - 4'd1) begin
          state_d = S_DRAIN;
        end else begin
          j_d     = j_q + 4'd1;
          state_d = S_BIAS;
        end
      end
      S_DRAIN: begin
        // once stage 1 is empty the last write is in flight this cycle
        if (!v1_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lr_q    <= '0;
      nw_q    <= '0;
      nb_q    <= '0;
      b_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      v1_q    <= 1'b0;
      bw1_q   <= 1'b0;
      wb1_q   <= 1'b0;
      a1_q    <= '0;
      v2_q    <= 1'b0;
      wb2_q   <= 1'b0;
      a2_q    <= '0;
    end else begin
      state_q <= state_d;
      lr_q    <= lr_d;
      nw_q    <= nw_d;
      nb_q    <= nb_d;
      b_q     <= b_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
      v1_q    <= iss;
      bw1_q   <= iss_bw;
      wb1_q   <= iss_wb;
      a1_q    <= iss_wa;
      v2_q    <= v1_q;
      wb2_q   <= v1_q & wb1_q;
      a2_q    <= a1_q;
    end
  end

  assign gd_lr_out             = lr_q;
  assign gd_valid_out          = v1_q;
  assign gd_value_old_out      = v1_q ? param_rd_data : 16'd0;
  assign gd_grad_out           = v1_q ? grad_rd_data : 16'd0;
  assign gd_bias_or_weight_out = v1_q & bw1_q;
  assign param_wr_en           = v2_q & wb2_q & gd_done_in;
  assign param_wr_addr         = param_wr_en ? a2_q : 10'd0;
  assign param_wr_data         = param_wr_en ? gd_value_updated_in : 16'd0;
  assign busy                  = (state_q != S_IDLE);
  assign done                  = done_q;

endmodule

// File: tb/tb_gd_sequencer.sv
// Directed bench for gd_sequencer with memory and GD-unit models.
// Each pass is logged at negedge and checked against hand-computed values.
module tb_gd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] lr_in = '0;
  logic [7:0]  nw_in = '0;
  logic [3:0]  nb_in = '0;
  logic [3:0]  b_in = '0;
  logic        param_rd_en, grad_rd_en;
  logic [9:0]  param_rd_addr, grad_rd_addr;
  logic [15:0] param_rd_data, grad_rd_data;
  logic [15:0] gd_lr_out, gd_value_old_out, gd_grad_out;
  logic        gd_valid_out, gd_bias_or_weight_out;
  logic [15:0] upd;
  logic        gdone;
  logic        param_wr_en;
  logic [9:0]  param_wr_addr;
  logic [15:0] param_wr_data;
  logic        busy, done;

  gd_sequencer dut (
    .clk                   (clk),
    .rst                   (rst),
    .start                 (start),
    .lr_in                 (lr_in),
    .num_weights_in        (nw_in),
    .num_biases_in         (nb_in),
    .batch_in              (b_in),
    .param_rd_en           (param_rd_en),
    .param_rd_addr         (param_rd_addr),
    .param_rd_data         (param_rd_data),
    .grad_rd_en            (grad_rd_en),
    .grad_rd_addr          (grad_rd_addr),
    .grad_rd_data          (grad_rd_data),
    .gd_lr_out             (gd_lr_out),
    .gd_value_old_out      (gd_value_old_out),
    .gd_grad_out           (gd_grad_out),
    .gd_valid_out          (gd_valid_out),
    .gd_bias_or_weight_out (gd_bias_or_weight_out),
    .gd_value_updated_in   (upd),
    .gd_done_in            (gdone),
    .param_wr_en           (param_wr_en),
    .param_wr_addr         (param_wr_addr),
    .param_wr_data         (param_wr_data),
    .busy                  (busy),
    .done                  (done)
  );

  always #5 clk = ~clk;

  logic [15:0] pmem [0:1023];
  logic [15:0] gmem [0:1023];

  always @(posedge clk) begin
    if (param_rd_en) param_rd_data <= pmem[param_rd_addr];
    if (grad_rd_en)  grad_rd_data  <= gmem[grad_rd_addr];
  end

  // GD unit: new = old - lr*grad (Q8.8); consecutive bias issues chain
  logic        pbw;
  logic        chain;
  logic [15:0] base;
  logic signed [31:0] prod;
  assign chain = gd_valid_out && gdone && !pbw && !gd_bias_or_weight_out;
  assign base  = chain ? upd : gd_value_old_out;
  assign prod  = $signed(gd_lr_out) * $signed(gd_grad_out);

  always @(posedge clk) begin
    if (rst) begin
      gdone <= 1'b0;
      pbw   <= 1'b0;
      upd   <= '0;
    end else begin
      gdone <= gd_valid_out;
      pbw   <= gd_bias_or_weight_out;
      if (gd_valid_out) upd <= base - prod[23:8];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wr_cyc[$], wr_addr[$], wr_data[$];
  int done_cyc[$], prd[$], prd_cyc[$], grd[$];
  logic busy_h  [0:4095];
  logic valid_h [0:4095];
  logic bw_h    [0:4095];
  logic [15:0] lr_h [0:4095];

  always @(negedge clk) begin
    if (param_wr_en) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(int'(param_wr_addr));
      wr_data.push_back(int'(param_wr_data));
    end
    if (done) done_cyc.push_back(cyc);
    if (param_rd_en) begin
      prd.push_back(int'(param_rd_addr));
      prd_cyc.push_back(cyc);
    end
    if (grad_rd_en) grd.push_back(int'(grad_rd_addr));
    busy_h[cyc % 4096]  = busy;
    valid_h[cyc % 4096] = gd_valid_out;
    bw_h[cyc % 4096]    = gd_bias_or_weight_out;
    lr_h[cyc % 4096]    = gd_lr_out;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int i,
                        input int ec, input int ea, input int ed);
    int n;
    n = wr_cyc.size();
    chk({tag, "_cyc"},  (i < n) ? wr_cyc[i]  : -1, ec);
    chk({tag, "_addr"}, (i < n) ? wr_addr[i] : -1, ea);
    chk({tag, "_data"}, (i < n) ? wr_data[i] : -1, ed);
  endtask

  task automatic chk_done(input string tag, input int d0, input int ec);
    chk({tag, "_ndone"}, done_cyc.size() - d0, 1);
    chk({tag, "_donecyc"}, (d0 < done_cyc.size()) ? done_cyc[d0] : -1, ec);
  endtask

  task automatic go(input logic [15:0] lr, input logic [7:0] w,
                    input logic [3:0] nb, input logic [3:0] bb,
                    output int s);
    @(posedge clk); #1;
    lr_in = lr; nw_in = w; nb_in = nb; b_in = bb;
    start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int s, w0, d0, p0, g0, r;
    for (int a = 0; a < 1024; a++) begin
      pmem[a] = '0;
      gmem[a] = '0;
    end

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(gd_valid_out), 0);
    chk("rst_wr", int'(param_wr_en), 0);
    chk("rst_rd", int'(param_rd_en | grad_rd_en), 0);
    chk("rst_lr", int'(gd_lr_out), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single weight
    pmem[0] = 16'h0100; gmem[0] = 16'h0200;
    w0 = wr_cyc.size(); d0 = done_cyc.size();
    go(16'h0080, 8'd1, 4'd0, 4'd1, s);
    repeat (10) @(posedge clk);
    chk("w1_nwr", wr_cyc.size() - w0, 1);
    chk_wr("w1", w0, s + 3, 0, 16'h0000);
    chk_done("w1", d0, s + 4);
    chk("w1_busy0", int'(busy_h[s % 4096]), 0);
    chk("w1_busy1", int'(busy_h[(s + 1) % 4096]), 1);
    chk("w1_busy4", int'(busy_h[(s + 4) % 4096]), 0);
    chk("w1_lr", int'(lr_h[(s + 2) % 4096]), 16'h0080);

    // four weights back to back
    for (int a = 0; a < 4; a++) begin
      pmem[a] = 16'((a + 1) * 256);
      gmem[a] = 16'h0100;
    end
    w0 = wr_cyc.size(); d0 = done_cyc.size(); p0 = prd.size();
    go(16'h0100, 8'd4, 4'd0, 4'd1, s);
    repeat (12) @(posedge clk);
    chk("w4_nrd", prd.size() - p0, 4);
    for (int a = 0; a < 4; a++) begin
      chk("w4_rdaddr", prd[p0 + a], a);
      chk("w4_rdcyc", prd_cyc[p0 + a], s + 1 + a);
    end
    chk("w4_nwr", wr_cyc.size() - w0, 4);
    chk_wr("w4_0", w0,     s + 3, 0, 16'h0000);
    chk_wr("w4_1", w0 + 1, s + 4, 1, 16'h0100);
    chk_wr("w4_2", w0 + 2, s + 5, 2, 16'h0200);
    chk_wr("w4_3", w0 + 3, s + 6, 3, 16'h0300);
    chk_done("w4", d0, s + 7);

    // two biases, batch 2
    pmem[0] = 16'h0100; pmem[1] = 16'h0200;
    for (int a = 0; a < 4; a++) gmem[a] = 16'h0100;
    w0 = wr_cyc.size(); d0 = done_cyc.size(); g0 = grd.size();
    go(16'h0080, 8'd0, 4'd2, 4'd2, s);
    repeat (14) @(posedge clk);
    chk("b2_ngrd", grd.size() - g0, 4);
    chk("b2_grd3", (g0 + 3 < grd.size()) ? grd[g0 + 3] : -1, 3);
    chk("b2_nwr", wr_cyc.size() - w0, 2);
    chk_wr("b2_0", w0,     s + 4, 0, 16'h0000);
    chk_wr("b2_1", w0 + 1, s + 7, 1, 16'h0100);
    chk("b2_v3", int'(valid_h[(s + 3) % 4096]), 1);
    chk("b2_gap", int'(valid_h[(s + 4) % 4096]), 0);
    chk("b2_v5", int'(valid_h[(s + 5) % 4096]), 1);
    chk_done("b2", d0, s + 8);

    // two weights, one bias of batch 3
    pmem[0] = 16'h0500; pmem[1] = 16'h0600; pmem[2] = 16'h1000;
    gmem[0] = 16'h0100; gmem[1] = 16'h0200;
    gmem[2] = 16'h0100; gmem[3] = 16'h0200; gmem[4] = 16'h0300;
    w0 = wr_cyc.size(); d0 = done_cyc.size();
    p0 = prd.size(); g0 = grd.size();
    go(16'h0100, 8'd2, 4'd1, 4'd3, s);
    repeat (14) @(posedge clk);
    chk("m_ngrd", grd.size() - g0, 5);
    for (int a = 0; a < 5; a++)
      chk("m_grd", (g0 + a < grd.size()) ? grd[g0 + a] : -1, a);
    chk("m_nprd", prd.size() - p0, 3);
    chk("m_prd2", (p0 + 2 < prd.size()) ? prd[p0 + 2] : -1, 2);
    chk("m_nwr", wr_cyc.size() - w0, 3);
    chk_wr("m_0", w0,     s + 3, 0, 16'h0400);
    chk_wr("m_1", w0 + 1, s + 4, 1, 16'h0400);
    chk_wr("m_2", w0 + 2, s + 7, 2, 16'h0A00);
    chk("m_bw3", int'(bw_h[(s + 3) % 4096]), 1);
    chk("m_bw4", int'(bw_h[(s + 4) % 4096]), 0);
    chk_done("m", d0, s + 8);

    // batch 0 counts as 1
    pmem[0] = 16'h0300; gmem[0] = 16'h0100;
    w0 = wr_cyc.size(); d0 = done_cyc.size();
    go(16'h0100, 8'd0, 4'd1, 4'd0, s);
    repeat (10) @(posedge clk);
    chk("b0_nwr", wr_cyc.size() - w0, 1);
    chk_wr("b0", w0, s + 3, 0, 16'h0200);
    chk_done("b0", d0, s + 4);

    // start while busy is ignored
    for (int a = 0; a < 3; a++) begin
      pmem[a] = 16'((a + 1) * 256);
      gmem[a] = 16'h0100;
    end
    w0 = wr_cyc.size(); d0 = done_cyc.size();
    go(16'h0100, 8'd3, 4'd0, 4'd1, s);
    @(posedge clk); #1;
    lr_in = 16'h7777; nw_in = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    chk("ds_nwr", wr_cyc.size() - w0, 3);
    chk_wr("ds_2", w0 + 2, s + 5, 2, 16'h0200);
    chk("ds_lr", int'(lr_h[(s + 3) % 4096]), 16'h0100);
    chk_done("ds", d0, s + 6);

    // reset mid-WEIGHTS aborts the pass
    w0 = wr_cyc.size(); d0 = done_cyc.size(); p0 = prd.size();
    go(16'h0100, 8'd8, 4'd0, 4'd1, s);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (15) @(posedge clk);
    chk("ab_busy", int'(busy_h[(s + 4) % 4096]), 0);
    chk("ab_nrd", prd.size() - p0, 3);
    chk("ab_nwr", wr_cyc.size() - w0, 1);
    chk("ab_ndone", done_cyc.size() - d0, 0);

    // start coincident with reset is ignored
    w0 = wr_cyc.size(); d0 = done_cyc.size();
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; nw_in = 8'd1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    r = cyc;
    repeat (8) @(posedge clk);
    chk("rs_busy0", int'(busy_h[r % 4096]), 0);
    chk("rs_busy2", int'(busy_h[(r + 2) % 4096]), 0);
    chk("rs_nwr", wr_cyc.size() - w0, 0);
    chk("rs_ndone", done_cyc.size() - d0, 0);

    // empty pass
    w0 = wr_cyc.size(); d0 = done_cyc.size();
    p0 = prd.size(); g0 = grd.size();
    go(16'h0100, 8'd0, 4'd0, 4'd1, s);
    repeat (8) @(posedge clk);
    chk_done("em", d0, s + 2);
    chk("em_busy1", int'(busy_h[(s + 1) % 4096]), 1);
    chk("em_busy2", int'(busy_h[(s + 2) % 4096]), 0);
    chk("em_nwr", wr_cyc.size() - w0, 0);
    chk("em_nrd", (prd.size() - p0) + (grd.size() - g0), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
